// File: rtl/axppa_pkg.sv
// axppa_pkg: shared widths and FSM state type for the approximate-adder error monitor
package axppa_pkg;
  localparam int ADD_W = 16;
  localparam int CNT_W = 16;
  localparam int ED_SUM_W = ADD_W + 1 + CNT_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/axppa_error_monitor_if.sv
// axppa_error_monitor_if: sample handshake carrying operands and approximate adder result
interface axppa_error_monitor_if import axppa_pkg::*; #(parameter int W = ADD_W);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic cin;
  logic [W:0] approx_sum;
  modport master(output in_valid, a, b, cin, approx_sum, input in_ready);
  modport slave(input in_valid, a, b, cin, approx_sum, output in_ready);
endinterface

// File: rtl/axppa_ed_calc.sv
// axppa_ed_calc: unsigned error distance between exact and approximate sums
module axppa_ed_calc import axppa_pkg::*; #(parameter int W = ADD_W) (
  input  logic [W:0] exact,
  input  logic [W:0] approx,
  output logic [W:0] ed,
  output logic       nz
);
  assign ed = exact >= approx ? exact - approx : approx - exact;
  assign nz = |ed;
endmodule

// File: rtl/axppa_error_monitor.sv
// axppa_error_monitor: accumulates ER/MED statistics of an approximate adder over N samples
module axppa_error_monitor import axppa_pkg::*; #(
  parameter int W = axppa_pkg::ADD_W,
  parameter int CNT_W = axppa_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  axppa_error_monitor_if.slave up,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [W+CNT_W:0]     ed_sum,
  output logic [W:0]           max_ed,
  output logic                 first_err_vld,
  output logic [CNT_W-1:0]     first_err_idx
);
  state_t state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accept_cnt;
  logic s1_vld;
  logic [W:0] s1_exact;
  logic [W:0] s1_approx;
  logic [W:0] ed;
  logic ed_nz;
  logic accept;
  logic launch;
  assign up.in_ready = state == RUN && accept_cnt < target;
  assign accept = up.in_valid & up.in_ready;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign launch = start && (state == IDLE || state == DONE);
  axppa_ed_calc #(.W(W)) u_ed (.exact(s1_exact), .approx(s1_approx), .ed(ed), .nz(ed_nz));
  // Run control: a zero-length run completes immediately; DRAIN waits for the last sample to clear S1
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      target <= '0;
      accept_cnt <= '0;
    end else if (launch) begin
      target <= num_samples;
      accept_cnt <= '0;
      state <= num_samples == '0 ? DONE : RUN;
    end else if (accept) begin
      accept_cnt <= accept_cnt + CNT_W'(1);
      state <= accept_cnt == target - CNT_W'(1) ? DRAIN : RUN;
    end else if (state == DRAIN && !s1_vld) begin
      state <= DONE;
    end
  end
  // S1: capture the exact reference sum alongside the adder's result
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_exact <= '0;
      s1_approx <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_exact <= (W+1)'(up.a) + (W+1)'(up.b) + (W+1)'(up.cin);
        s1_approx <= up.approx_sum;
      end
    end
  end
  // S2: fold each sample's error distance into the run statistics
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      sample_cnt <= '0;
      err_cnt <= '0;
      ed_sum <= '0;
      max_ed <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if (s1_vld) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_cnt <= err_cnt + CNT_W'(ed_nz);
      ed_sum <= ed_sum + (W+CNT_W+1)'(ed);
      max_ed <= ed > max_ed ? ed : max_ed;
      first_err_vld <= first_err_vld | ed_nz;
      first_err_idx <= ed_nz && !first_err_vld ? sample_cnt : first_err_idx;
    end
  end
endmodule

// File: tb/tb_axppa_error_monitor.sv
// tb_axppa_error_monitor: randomized self-checking bench with an arithmetic statistics model
module tb_axppa_error_monitor;
  localparam int W = 16;
  localparam int CW = 16;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [CW-1:0] num_samples = '0;
  logic busy, done, first_err_vld;
  logic [CW-1:0] sample_cnt, err_cnt, first_err_idx;
  logic [W+CW:0] ed_sum;
  logic [W:0] max_ed;
  axppa_error_monitor_if #(.W(W)) ifc ();
  axppa_error_monitor #(.W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .up(ifc), .start(start), .num_samples(num_samples),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .ed_sum(ed_sum), .max_ed(max_ed), .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_rdy = 0;
  always @(posedge clk) begin
    if (ifc.in_valid && ifc.in_ready) n_acc++;
    if (ifc.in_ready) n_rdy++;
  end
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic qc[$];
  logic [W:0] qx[$];
  logic [CW-1:0] e_cnt, e_err, e_fi;
  logic [W+CW:0] e_sum;
  logic [W:0] e_max;
  logic e_fv;
  function automatic string got_s();
    return $sformatf("cnt=%0d err=%0d sum=%0d max=%0h fv=%0b fi=%0d", sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx);
  endfunction
  function automatic string exp_s();
    return $sformatf("cnt=%0d err=%0d sum=%0d max=%0h fv=%0b fi=%0d", e_cnt, e_err, e_sum, e_max, e_fv, e_fi);
  endfunction
  task automatic model();
    e_cnt = '0; e_err = '0; e_fi = '0; e_sum = '0; e_max = '0; e_fv = 1'b0;
    for (int i = 0; i < qa.size(); i++) begin
      int d;
      d = int'(qa[i]) + int'(qb[i]) + int'(qc[i]) - int'(qx[i]);
      if (d < 0) d = -d;
      if (d != 0) begin
        if (!e_fv) begin e_fv = 1'b1; e_fi = CW'(i); end
        e_err = e_err + 1;
      end
      e_cnt = e_cnt + 1;
      e_sum = e_sum + (W+CW+1)'(d);
      if (d > int'(e_max)) e_max = (W+1)'(d);
    end
  endtask
  task automatic clear_q();
    qa.delete(); qb.delete(); qc.delete(); qx.delete();
  endtask
  task automatic add(input int a, input int b, input int c, input int x);
    qa.push_back(W'(a)); qb.push_back(W'(b)); qc.push_back(c[0]); qx.push_back((W+1)'(x));
  endtask
  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++) begin
      int a, b, c, ex, x;
      a = int'($urandom_range(16'hFFFF)); b = int'($urandom_range(16'hFFFF)); c = int'($urandom_range(1));
      ex = a + b + c;
      case ($urandom_range(3))
        0: x = ex;
        1: x = ex ^ (1 << $urandom_range(16));
        2: x = int'($urandom_range(17'h1FFFF));
        default: x = ex - int'($urandom_range(7));
      endcase
      add(a, b, c, x & 17'h1FFFF);
    end
  endtask
  task automatic present(input int k);
    ifc.a = qa[k]; ifc.b = qb[k]; ifc.cin = qc[k]; ifc.approx_sum = qx[k];
  endtask
  task automatic pulse_start(input int n);
    @(negedge clk);
    start = 1; num_samples = CW'(n);
    @(negedge clk);
    start = 0;
  endtask
  task automatic feed(input int gap_pct);
    int k = 0;
    for (int t = 0; t < 2000 && k < qa.size(); t++) begin
      ifc.in_valid = $urandom_range(99) >= gap_pct;
      present(k);
      if (ifc.in_valid && ifc.in_ready) k++;
      @(negedge clk);
    end
    ifc.in_valid = 0;
  endtask
  task automatic wait_done();
    for (int t = 0; t < 20 && !done; t++) @(negedge clk);
  endtask
  task automatic run(input int gap_pct);
    model();
    pulse_start(qa.size());
    feed(gap_pct);
    wait_done();
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_chk++;
    if ({ifc.in_ready, busy, done, sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx} !== '0) begin
      n_fail++; $display("FAIL reset_state: rdy=%0b busy=%0b done=%0b %s, want all zero", ifc.in_ready, busy, done, got_s());
    end
  endtask
  task automatic test_exact();
    clear_q();
    repeat (4) add(16'h1234, 16'h0001, 0, 17'h01235);
    run(0);
    n_chk++;
    if (done !== 1'b1 || sample_cnt !== 16'd4 || err_cnt !== 16'd0 || ed_sum !== '0 || max_ed !== '0 || first_err_vld !== 1'b0) begin
      n_fail++; $display("FAIL exact_match: done=%0b %s, want done=1 cnt=4 err=0 sum=0 max=0 fv=0", done, got_s());
    end
    n_chk++;
    if ({sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx} !== {e_cnt, e_err, e_sum, e_max, e_fv, e_fi}) begin
      n_fail++; $display("FAIL exact_model: got %s want %s", got_s(), exp_s());
    end
  endtask
  task automatic test_single_err();
    clear_q();
    add(16'h0001, 16'h0001, 0, 17'h00002);
    add(16'h00FF, 16'h0001, 0, 17'h000FC);
    add(16'h0002, 16'h0003, 0, 17'h00005);
    run(40);
    n_chk++;
    if (done !== 1'b1 || err_cnt !== 16'd1 || ed_sum !== 33'd4 || max_ed !== 17'd4 || first_err_vld !== 1'b1 || first_err_idx !== 16'd1) begin
      n_fail++; $display("FAIL single_err: done=%0b %s, want err=1 sum=4 max=4 fv=1 fi=1", done, got_s());
    end
  endtask
  task automatic test_sign_mag();
    clear_q();
    add(0, 0, 0, 17'h1FFFF);
    run(0);
    n_chk++;
    if (done !== 1'b1 || max_ed !== 17'h1FFFF || ed_sum !== 33'd131071 || err_cnt !== 16'd1 || first_err_idx !== 16'd0 || first_err_vld !== 1'b1) begin
      n_fail++; $display("FAIL sign_mag: done=%0b %s, want max=1ffff sum=131071 err=1 fi=0", done, got_s());
    end
  endtask
  task automatic test_zero_target();
    n_rdy = 0;
    pulse_start(0);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: done=%0b busy=%0b, want done=1 busy=0", done, busy);
    end
    ifc.in_valid = 1;
    repeat (3) @(negedge clk);
    ifc.in_valid = 0;
    n_chk++;
    if (n_rdy !== 0 || {sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx} !== '0) begin
      n_fail++; $display("FAIL zero_stats: ready_cycles=%0d %s, want 0 and all zero", n_rdy, got_s());
    end
  endtask
  task automatic test_throttle();
    bit pat[6] = '{1, 0, 1, 1, 1, 1};
    int k = 0;
    bit pulsed = 0;
    clear_q();
    add_rand(3);
    model();
    pulse_start(3);
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      ifc.in_valid = pat[i];
      present(k < 3 ? k : 2);
      start = busy && !ifc.in_ready && !pulsed;
      if (start) begin pulsed = 1; num_samples = 16'd7; end
      if (ifc.in_valid && ifc.in_ready) k++;
      @(negedge clk);
    end
    ifc.in_valid = 0;
    start = 0;
    wait_done();
    n_chk++;
    if (n_acc !== 3) begin
      n_fail++; $display("FAIL throttle_accepts: got %0d, want 3", n_acc);
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 16'd3) begin
      n_fail++; $display("FAIL throttle_drain_start: done=%0b busy=%0b cnt=%0d, want done=1 busy=0 cnt=3", done, busy, sample_cnt);
    end
    n_chk++;
    if ({sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx} !== {e_cnt, e_err, e_sum, e_max, e_fv, e_fi}) begin
      n_fail++; $display("FAIL throttle_model: got %s want %s", got_s(), exp_s());
    end
  endtask
  task automatic test_reset_mid_run();
    int k = 0;
    clear_q();
    add_rand(10);
    pulse_start(10);
    for (int t = 0; t < 50 && k < 5; t++) begin
      ifc.in_valid = 1;
      present(k);
      if (ifc.in_ready) k++;
      @(negedge clk);
    end
    ifc.in_valid = 0;
    rst = 1;
    @(negedge clk);
    n_chk++;
    if ({ifc.in_ready, busy, done, sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx} !== '0) begin
      n_fail++; $display("FAIL mid_reset: rdy=%0b busy=%0b done=%0b %s, want all zero", ifc.in_ready, busy, done, got_s());
    end
    rst = 0;
    clear_q();
    add_rand(4);
    run(20);
    n_chk++;
    if (done !== 1'b1 || {sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx} !== {e_cnt, e_err, e_sum, e_max, e_fv, e_fi}) begin
      n_fail++; $display("FAIL after_reset_run: done=%0b got %s want %s", done, got_s(), exp_s());
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_q();
      add_rand(int'($urandom_range(24, 1)));
      run(30);
      n_chk++;
      if (done !== 1'b1 || {sample_cnt, err_cnt, ed_sum, max_ed, first_err_vld, first_err_idx} !== {e_cnt, e_err, e_sum, e_max, e_fv, e_fi}) begin
        n_fail++; $display("FAIL random_run%0d: done=%0b got %s want %s", it, done, got_s(), exp_s());
      end
    end
  endtask
  initial begin
    ifc.in_valid = 0; ifc.a = '0; ifc.b = '0; ifc.cin = 0; ifc.approx_sum = '0;
    test_reset();
    test_exact();
    test_single_err();
    test_sign_mag();
    test_zero_target();
    test_throttle();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axppa_error_monitor.md
Name: axppa_error_monitor

Overview:
- Sequential error-characterisation stage that sits directly downstream of the 16-bit approximate parallel-prefix adder.
- Each accepted sample carries the operands and the adder's result. The block computes the exact sum internally and derives the error distance (ED).
- Over a programmed run of N samples it accumulates sample count, erroneous-sample count, ED sum and maximum ED, and captures the index of the first erroneous sample.
- Used on silicon or FPGA to produce ER/MED figures for each approximation variant.

Parameters:
- W, 16, operand width; the approximate result is W+1 bits {carry_out, sum}.
- CNT_W, 16, width of the sample-target and sample-count fields.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: latch num_samples, clear statistics, begin run.
- num_samples  input  CNT_W  samples to accept in this run.
- in_valid  input  1  sample present on a, b, cin, approx_sum.
- in_ready  output  1  block accepts a sample this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in; the exact reference is a+b+cin.
- approx_sum  input  W+1  adder result {Carry_Out[W], Sum[W:1]}.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  state is DONE; statistics are final and stable.
- sample_cnt  output  CNT_W  samples accumulated.
- err_cnt  output  CNT_W  samples with ED != 0.
- ed_sum  output  W+1+CNT_W  sum of ED.
- max_ed  output  W+1  largest ED seen.
- first_err_vld  output  1  at least one erroneous sample seen.
- first_err_idx  output  CNT_W  0-based index of the first erroneous sample.

Behaviour:
- Reset (synchronous, active-high): state IDLE; every output and internal register is 0; in_ready=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: latch target=num_samples; clear all statistics and first_err_*; go to RUN. If num_samples==0, go straight to DONE instead; done rises the cycle after start.
  - RUN: in_ready=1 while accept_cnt<target.
    - Accept = in_valid & in_ready.
    - On the accept that makes accept_cnt==target, go to DRAIN.
  - DRAIN: in_ready=0; wait until the pipeline is empty, then go to DONE.
  - DONE: hold all statistics; done=1 until the next start or rst.
- start while busy is ignored. in_valid outside RUN, or while in_ready=0, is ignored and not counted.
- Pipeline, 2 stages:
  - S1 registers exact=a+b+cin (W+1 bits, zero-extended), approx_sum, and a valid bit.
  - S2 computes ED=|exact-approx_sum| as an unsigned magnitude (W+1 bits; either sign of the difference is possible) and updates statistics:
    - sample_cnt+=1.
    - If ED!=0: err_cnt+=1; if first_err_vld==0, set first_err_vld=1 and first_err_idx=sample_cnt (pre-increment value).
    - ed_sum+=ED.
    - max_ed=max(max_ed,ED).
- Statistics visible 2 cycles after acceptance. done asserts no earlier than 3 cycles after the last accept.
- ed_sum width is chosen so overflow is impossible: (2^CNT_W-1)*(2^(W+1)-1) < 2^(W+1+CNT_W). No saturation logic.
- Back-to-back accepts at one per cycle are supported; gaps in in_valid are allowed.
- Reset mid-run: abandon the run, return to IDLE, clear everything; no partial results are retained.

Decomposition:
- Shared package axppa_pkg holds:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - Default widths ADD_W=16, CNT_W=16.
  - Localparam for the ed_sum width (ADD_W+1+CNT_W).
- One natural sub-module, axppa_ed_calc: combinational exact-vs-approx absolute difference and nonzero flag, W as parameter. It is reused by later per-bit error profilers.

Test Plan:
- Exact match: start, N=4; four samples a=0x1234, b=0x0001, cin=0, approx_sum=0x01235 -> done; sample_cnt=4, err_cnt=0, ed_sum=0, max_ed=0, first_err_vld=0.
- Single approximation error: N=3; samples (0x0001,0x0001,0,0x00002), (0x00FF,0x0001,0,0x000FC), (0x0002,0x0003,0,0x00005) -> err_cnt=1, ED=4 (exact 0x00100), ed_sum=4, max_ed=4, first_err_idx=1.
- Sign/magnitude: N=1; a=0, b=0, cin=0, approx_sum=0x1FFFF -> max_ed=0x1FFFF, ed_sum=131071, err_cnt=1, first_err_idx=0.
- Zero target: start with N=0 -> done=1 on the next cycle; in_ready never asserted; all statistics 0.
- Throttling: N=3; in_valid pattern 1,0,1,1,1,1 -> exactly 3 accepts; in_ready drops after the 3rd; sample_cnt=3; a start pulse during DRAIN is ignored.
- Reset mid-run: N=10; assert rst after 5 accepts -> next cycle state IDLE, busy=0, done=0, all counters 0; a fresh start runs normally.
